// File: rtl/dram_pkg.sv
// Shared types and default constants for the DRAM arbiter slice.
//   state_t    : arbiter FSM states
//   port_idx_t : requester index (PORT0 = CPU/mem_map, PORT1 = auxiliary)
package dram_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_idx_t;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 64;

endpackage

// File: rtl/dram_arb_pick.sv
// Combinational two-port grant selection.
//   p0_valid, p1_valid : pending requests
//   starve_cnt         : consecutive port-1 losses so far
//   grant_valid        : at least one request pending
//   grant              : winning port index
module dram_arb_pick
    import dram_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             p0_valid,
    input  logic             p1_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_valid,
    output port_idx_t        grant
);

    always_comb begin
        grant_valid = p0_valid | p1_valid;
        grant       = PORT0;
        // Port 0 has priority unless port 1 has lost STARVE_MAX times in a row.
        if (p1_valid && (!p0_valid || starve_cnt == CNT_W'(STARVE_MAX))) begin
            grant = PORT1;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-requester arbiter in front of a single-command DRAM controller.
//   clk, rst                      : clock, async active-high reset
//   pN_valid/write/addr/wdata     : request from port N (held until pN_ack)
//   pN_ack                        : one-cycle accept pulse
//   pN_done, pN_rdata             : one-cycle completion pulse, read data (held)
//   ctl_start                     : one-cycle command strobe to controller
//   ctl_write_en/addr/data_in     : latched command, stable through WAIT
//   ctl_done, ctl_data_out        : controller completion and read data
//   busy                          : FSM not idle
//   err                           : sticky controller timeout flag
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_valid,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_valid,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              ctl_start,
    output logic              ctl_write_en,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_data_in,
    input  logic              ctl_done,
    input  logic [DATA_W-1:0] ctl_data_out,

    output logic              busy,
    output logic              err
);

    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    port_idx_t         owner;
    port_idx_t         grant;
    logic              grant_valid;
    logic [CNT_W-1:0]  starve_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_last;
    logic [DATA_W-1:0] resp_rdata;

    dram_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .p0_valid    (p0_valid),
        .p1_valid    (p1_valid),
        .starve_cnt  (starve_cnt),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign busy = (state != S_IDLE);

    // wait_cnt holds the number of WAIT cycles already elapsed, so the current
    // cycle is the TIMEOUT-th one when wait_cnt == TIMEOUT-1; a ctl_done in
    // that same cycle still wins over the timeout.
    assign wait_last = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        resp_rdata = '0;
        if (ctl_done && !ctl_write_en) begin
            resp_rdata = ctl_data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            owner        <= PORT0;
            starve_cnt   <= '0;
            wait_cnt     <= '0;
            err          <= 1'b0;
            p0_ack       <= 1'b0;
            p1_ack       <= 1'b0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
            ctl_start    <= 1'b0;
            ctl_write_en <= 1'b0;
            ctl_addr     <= '0;
            ctl_data_in  <= '0;
        end else begin
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            ctl_start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant;
                        wait_cnt <= '0;
                        state    <= S_ISSUE;
                        if (grant == PORT1) begin
                            p1_ack       <= 1'b1;
                            ctl_write_en <= p1_write;
                            ctl_addr     <= p1_addr;
                            ctl_data_in  <= p1_wdata;
                            starve_cnt   <= '0;
                        end else begin
                            p0_ack       <= 1'b1;
                            ctl_write_en <= p0_write;
                            ctl_addr     <= p0_addr;
                            ctl_data_in  <= p0_wdata;
                            if (p1_valid && starve_cnt != CNT_W'(STARVE_MAX)) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end
                    end
                end

                S_ISSUE: begin
                    ctl_start <= 1'b1;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    if (ctl_done || wait_last) begin
                        if (!ctl_done) begin
                            err <= 1'b1;
                        end
                        if (owner == PORT1) begin
                            p1_done  <= 1'b1;
                            p1_rdata <= resp_rdata;
                        end else begin
                            p0_done  <= 1'b1;
                            p0_rdata <= resp_rdata;
                        end
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
